mult_div_unit: RTL and testbench

- Iterative 16-bit multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register-file read operands and produces a 32-bit result as hi/lo words.
- The control unit raises start, then stalls issue while busy is high.
- Results feed the writeback path, from which they return to the register file.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mult_div_unit_step.sv | 42 ++++
 rtl/mult_div_unit.sv | 186 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operand width,
// op encodings, FSM state encoding and small op-decoding helpers.
package mdu_pkg;

  localparam int MDU_WIDTH = 16;

  // Operation encodings; bit 1 selects divide, bit 0 selects signed.
  localparam logic [1:0] MDU_MULU = 2'b00;
  localparam logic [1:0] MDU_MUL  = 2'b01;
  localparam logic [1:0] MDU_DIVU = 2'b10;
  localparam logic [1:0] MDU_DIV  = 2'b11;

  // Sequencer states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  function automatic logic op_is_div(input logic [1:0] op_f);
    return op_f[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op_f);
    return op_f[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_step.sv
// One radix-2 iteration of the multiply/divide datapath, purely combinational.
// The accumulator is {high_half, low_half}:
//   multiply: {partial product, remaining multiplier bits}, shifted right
//   divide:   {partial remainder, remaining dividend / quotient bits}, shifted left
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic               div_mode_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   partial;
  logic [WIDTH+1:0] diff;
  logic             ge;

  // Shift-add multiply step or restoring-divide step, selected by mode
  always_comb begin
    // Add multiplicand to the upper half when the current multiplier bit is
    // set; the carry becomes the new MSB after the right shift.
    mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);

    // Remainder shifted left with the next dividend bit brought in; it can
    // exceed WIDTH bits by one before the trial subtract.
    partial = acc_i[2*WIDTH-1:WIDTH-1];
    diff    = {1'b0, partial} - {2'b00, operand_i};
    ge      = ~diff[WIDTH+1];

    if (div_mode_i) begin
      // After a successful subtract the remainder is below the divisor, so it
      // always fits back into WIDTH bits.
      acc_o = {WIDTH'(ge ? diff[WIDTH:0] : partial), acc_i[WIDTH-2:0], ge};
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative WIDTH x WIDTH multiply / WIDTH / WIDTH divide unit.
// Signed operands are reduced to magnitudes on acceptance, the core runs
// unsigned for WIDTH cycles, and signs are restored in the final state.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; hi/lo/dz hold the last completed result
// RUN   | one radix-2 iteration per cycle, WIDTH iterations in total
// FIX   | sign correction, hi/lo/dz written, done pulsed on exit
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 5   // 2**CNT_W must exceed WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dzp_q, dzp_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               div_by_zero;
  logic               div_q;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] res_fix;

  // Operand conditioning on the raw register-file inputs
  always_comb begin
    a_neg       = op_is_signed(op) & opa[WIDTH-1];
    b_neg       = op_is_signed(op) & opb[WIDTH-1];
    abs_a       = a_neg ? -opa : opa;
    abs_b       = b_neg ? -opb : opb;
    div_by_zero = op_is_div(op) && (opb == '0);
  end

  assign div_q = op_is_div(op_q);

  mdu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_i      (acc_q),
    .operand_i  (opnd_q),
    .div_mode_i (div_q),
    .acc_o      (acc_step)
  );

  // Sign restoration of the unsigned core result; the most-negative divide
  // overflow falls out naturally as the negated magnitude wraps to itself.
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    res_fix  = div_q ? {rem_fix, quot_fix} : prod_fix;
  end

  // Sequencer next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dzp_d   = dzp_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          op_d  = op;
          cnt_d = '0;
          if (div_by_zero) begin
            // Preload the final answer and skip the iterations; with the sign
            // flags clear, FIX passes the accumulator straight through.
            acc_d   = {opa, {WIDTH{1'b1}}};
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            dzp_d   = 1'b1;
            state_d = ST_FIX;
          end else begin
            opnd_d  = op_is_div(op) ? abs_b : abs_a;
            acc_d   = op_is_div(op) ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            neg_d   = a_neg ^ b_neg;
            rneg_d  = op_is_div(op) & a_neg;
            dzp_d   = 1'b0;
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = ST_FIX;
          end
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          hi_d   = res_fix[2*WIDTH-1:WIDTH];
          lo_d   = res_fix[WIDTH-1:0];
          dz_d   = dzp_q;
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_MULU;
      opnd_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dzp_q   <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dzp_q   <= dzp_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [1:0]   op;
  logic [W-1:0] opa, opb;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  // last completed result as the design should be holding it
  logic [W-1:0] exp_hi, exp_lo;
  logic         exp_dz;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // {dz, hi, lo} from plain integer arithmetic
  function automatic logic [32:0] ref_model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, q, r;
    logic [31:0] p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (o == 2'b00) begin
      p = {16'h0, a} * {16'h0, b};
      return {1'b0, p};
    end
    if (o == 2'b01) begin
      p = 32'(sa * sb);
      return {1'b0, p};
    end
    if (b == 16'h0) return {1'b1, a, 16'hFFFF};
    if (o == 2'b10) return {1'b0, a % b, a / b};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[15:0], q[15:0]};
  endfunction

  // Call at a negedge; returns at the negedge where done is seen.
  task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input bit poke);
    logic [32:0] e;
    int n;
    e = ref_model(o, a, b);
    op = o; opa = a; opb = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after_start", busy, 1);
    check_val("done_after_start", done, 0);
    n = 0;
    while (!done && n < 40) begin
      if (poke && n == 4) begin
        start = 1'b1;
        op    = 2'($urandom_range(0, 3));
        opa   = 16'($urandom);
        opb   = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check_val("latency", n, (o[1] && b == 16'h0) ? 1 : 17);
    check_val("busy_at_done", busy, 0);
    check_val("hi", hi, e[31:16]);
    check_val("lo", lo, e[15:0]);
    check_val("dz", dz, e[32]);
    exp_hi = e[31:16];
    exp_lo = e[15:0];
    exp_dz = e[32];
  endtask

  function automatic logic [15:0] rand_operand();
    logic [15:0] edges [5];
    edges = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    logic [15:0] ra, rb;
    logic [1:0]  ro;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; opa = '0; opb = '0;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_hi", hi, 0);
    check_val("rst_lo", lo, 0);
    check_val("rst_dz", dz, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic unsigned divide
    do_op(2'b10, 16'd14, 16'd4, 1'b0);
    check_val("divu14_4_lo", lo, 16'h0003);
    check_val("divu14_4_hi", hi, 16'h0002);

    // multiply corners
    do_op(2'b00, 16'hFFFF, 16'hFFFF, 1'b0);
    check_val("mulu_max", {hi, lo}, 32'hFFFE_0001);
    do_op(2'b01, 16'hFFFD, 16'h0005, 1'b0);
    check_val("mul_m3x5", {hi, lo}, 32'hFFFF_FFF1);

    // signed divide truncation and overflow
    do_op(2'b11, 16'hFFF9, 16'h0002, 1'b0);
    check_val("div_m7_2", {hi, lo}, 32'hFFFF_FFFD);
    do_op(2'b11, 16'h8000, 16'hFFFF, 1'b0);
    check_val("div_ovf", {hi, lo}, 32'h0000_8000);

    // divide by zero, then a multiply clears dz
    do_op(2'b10, 16'd14, 16'd0, 1'b0);
    check_val("dz_set", {15'h0, dz, hi, lo}, 32'h000E_FFFF | (32'h1 << 32'd32 - 1) & 32'h0);
    check_val("dz_flag", dz, 1);
    do_op(2'b00, 16'd2, 16'd3, 1'b0);
    check_val("dz_clear", dz, 0);
    check_val("mulu_2x3", lo, 16'd6);

    // flush mid-run; a start pulse while busy is ignored
    op = 2'b00; opa = 16'h00FF; opb = 16'h0100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    saw_done = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      start = (c == 5);
      flush = (c == 8);
      if (c == 5) begin opa = 16'h1234; opb = 16'h5678; end
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    start = 1'b0; flush = 1'b0;
    check_val("flush_busy", busy, 0);
    check_val("flush_hi_hold", hi, exp_hi);
    check_val("flush_lo_hold", lo, exp_lo);
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check_val("flush_no_done", saw_done, 0);
    check_val("flush_idle_busy", busy, 0);
    do_op(2'b00, 16'h00FF, 16'h0100, 1'b0);
    check_val("mulu_ff_100", lo, 16'hFF00);

    // flush beats a simultaneous start in IDLE
    @(negedge clk);
    op = 2'b00; opa = 16'd5; opb = 16'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check_val("idle_flush_busy", busy, 0);
    @(negedge clk);
    check_val("idle_flush_done", done, 0);
    check_val("idle_flush_lo", lo, exp_lo);

    // flush while in FIX (divide by zero goes there directly)
    op = 2'b10; opa = 16'd9; opb = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    check_val("fix_busy", busy, 1);
    @(negedge clk);
    flush = 1'b0;
    check_val("fix_flush_busy", busy, 0);
    check_val("fix_flush_done", done, 0);
    check_val("fix_flush_dz", dz, exp_dz);
    check_val("fix_flush_hi", hi, exp_hi);
    check_val("fix_flush_lo", lo, exp_lo);

    // asynchronous reset mid-divide
    do_op(2'b11, 16'hFF00, 16'h0007, 1'b0);
    @(negedge clk);
    op = 2'b11; opa = 16'h1234; opb = 16'h0011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("arst_busy", busy, 0);
    check_val("arst_done", done, 0);
    check_val("arst_hi", hi, 0);
    check_val("arst_lo", lo, 0);
    check_val("arst_dz", dz, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    @(negedge clk);
    do_op(2'b11, 16'h1234, 16'h0011, 1'b0);

    // randomized, mostly back-to-back with occasional idle gaps
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = rand_operand();
      rb = ($urandom_range(0, 9) == 0) ? 16'h0 : rand_operand();
      do_op(ro, ra, rb, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check_val("hold_hi", hi, exp_hi);
        check_val("hold_lo", lo, exp_lo);
        check_val("hold_dz", dz, exp_dz);
        check_val("hold_done", done, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
